// File: rtl/jelly_img_to_axi4s.sv
// Bridges a cke-throttled image stream onto AXI4-Stream through a first-word-fall-through FIFO.
// Upstream stalls via registered m_img_cke; CKE_MARGIN slots absorb upstream cke latency.
module jelly_img_to_axi4s #(
   parameter int USER_WIDTH     = 0,
   parameter int DATA_WIDTH     = 24,
   parameter int FIFO_PTR_WIDTH = 5,
   parameter int CKE_MARGIN     = 2,
   localparam int USER_BITS     = (USER_WIDTH > 0 ? USER_WIDTH : 1)
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  s_img_line_first,
   input  logic                  s_img_line_last,
   input  logic                  s_img_pixel_first,
   input  logic                  s_img_pixel_last,
   input  logic                  s_img_de,
   input  logic [USER_BITS-1:0]  s_img_user,
   input  logic [DATA_WIDTH-1:0] s_img_data,
   input  logic                  s_img_valid,
   output logic                  m_img_cke,

   output logic [USER_BITS:0]    m_axi4s_tuser,
   output logic                  m_axi4s_tlast,
   output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
   output logic                  m_axi4s_tvalid,
   input  logic                  m_axi4s_tready,

   output logic                  overflow
);

   localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;
   localparam int CNT_W = FIFO_PTR_WIDTH + 1;
   localparam int ENT_W = DATA_WIDTH + USER_BITS + 2;
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CKE_LIMIT = CNT_W'(DEPTH - CKE_MARGIN);

   logic [ENT_W-1:0]          mem_q [DEPTH];
   logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      cke_q, cke_d;
   logic                      overflow_q, overflow_d;

   logic                      push_req, push, pop, full;
   logic [ENT_W-1:0]          wr_entry, rd_entry;
   logic                      unused_line_last;

   // Line-last carries no information the AXI4-Stream side needs.
   assign unused_line_last = s_img_line_last;

   assign wr_entry = {s_img_line_first & s_img_pixel_first, s_img_pixel_last, s_img_user, s_img_data};
   assign rd_entry = mem_q[rd_ptr_q];

   always_comb begin
      push_req   = cke_q & s_img_valid & s_img_de;
      full       = (count_q == CNT_FULL);
      pop        = (count_q != '0) & m_axi4s_tready;
      push       = push_req & (~full | pop);
      overflow_d = overflow_q | (push_req & full & ~pop);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d   = push ? wr_ptr_q + FIFO_PTR_WIDTH'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + FIFO_PTR_WIDTH'(1) : rd_ptr_q;
      cke_d      = (count_d < CKE_LIMIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cke_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         cke_q      <= cke_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // Payload is masked while empty so it reads zero in reset and never exposes stale RAM.
   assign m_axi4s_tvalid = (count_q != '0);
   assign m_axi4s_tdata  = m_axi4s_tvalid ? rd_entry[DATA_WIDTH-1:0] : '0;
   assign m_axi4s_tuser  = m_axi4s_tvalid ? {rd_entry[DATA_WIDTH +: USER_BITS], rd_entry[ENT_W-1]} : '0;
   assign m_axi4s_tlast  = m_axi4s_tvalid & rd_entry[ENT_W-2];
   assign m_img_cke      = cke_q;
   assign overflow       = overflow_q;

endmodule
